// File: rtl/sub_pkg.sv
// Shared types for the pipelined subtractor. SUB_FLAGS_EN adds the operand
// MSBs to each stage so the last stage can form the signed-overflow flag.
package sub_pkg;
  localparam int SLICE_W = 16;
  localparam int DATA_W  = 64;

  typedef struct packed {
    logic              valid;
    logic              borrow;
    logic [DATA_W-1:0] hi_a;
    logic [DATA_W-1:0] hi_b;
    logic [DATA_W-1:0] lo_diff;
`ifdef SUB_FLAGS_EN
    logic [1:0]        msbs;   // {a[MSB], b[MSB]}
`endif
  } stage_t;
endpackage

// File: rtl/sub_slice.sv
// One SLICE-wide subtract with borrow: {bo, d} = a_s - b_s - bi.
module sub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_s,
  input  logic [W-1:0] b_s,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);
  assign {bo, d} = {1'b0, a_s} - {1'b0, b_s} - {{W{1'b0}}, bi};
endmodule

// File: rtl/pipelined_sub64.sv
// Pipelined WIDTH-bit subtractor, one SLICE per stage, valid/ready on both ends.
// Define SUB_FLAGS_EN to add zero/neg/ovf result flags.
module pipelined_sub64
  import sub_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);
  localparam int STAGES = WIDTH / SLICE;
  localparam int LAST   = STAGES - 1;

  stage_t st_q [STAGES];
  stage_t st_d [STAGES];

  logic [STAGES-1:0]            ld;
  logic [STAGES-1:0]            src_v;
  logic [STAGES-1:0]            src_bi;
  logic [STAGES-1:0]            bo_s;
  logic [STAGES-1:0][WIDTH-1:0] src_a;
  logic [STAGES-1:0][WIDTH-1:0] src_b;
  logic [STAGES-1:0][WIDTH-1:0] src_lo;
  logic [STAGES-1:0][SLICE-1:0] d_s;
`ifdef SUB_FLAGS_EN
  logic [STAGES-1:0][1:0]       src_msbs;
`endif

  // Each stage reads either the input port or the previous stage register;
  // remaining operand bits are pre-shifted so every stage uses the low slice.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_v[k]  = in_valid;
      assign src_bi[k] = borrow_in;
      assign src_a[k]  = a;
      assign src_b[k]  = b;
      assign src_lo[k] = '0;
`ifdef SUB_FLAGS_EN
      assign src_msbs[k] = {a[WIDTH-1], b[WIDTH-1]};
`endif
    end else begin : g_body
      assign src_v[k]  = st_q[k-1].valid;
      assign src_bi[k] = st_q[k-1].borrow;
      assign src_a[k]  = st_q[k-1].hi_a[WIDTH-1:0];
      assign src_b[k]  = st_q[k-1].hi_b[WIDTH-1:0];
      assign src_lo[k] = st_q[k-1].lo_diff[WIDTH-1:0];
`ifdef SUB_FLAGS_EN
      assign src_msbs[k] = st_q[k-1].msbs;
`endif
    end

    sub_slice #(.W(SLICE)) u_slice (
      .a_s (src_a[k][SLICE-1:0]),
      .b_s (src_b[k][SLICE-1:0]),
      .bi  (src_bi[k]),
      .d   (d_s[k]),
      .bo  (bo_s[k])
    );
  end

  // A stage may load when it is empty or its contents move on this edge.
  always_comb begin
    ld       = '0;
    ld[LAST] = !st_q[LAST].valid || out_ready;
    for (int k = LAST - 1; k >= 0; k--)
      ld[k] = !st_q[k].valid || ld[k+1];
  end

  // New diff slices enter at the top of lo_diff and drift down one slice per
  // stage, so after the last stage slice 0 sits at bit 0.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = st_q[k];
      if (ld[k]) begin
        st_d[k].valid   = src_v[k];
        st_d[k].borrow  = bo_s[k];
        st_d[k].hi_a    = DATA_W'(src_a[k] >> SLICE);
        st_d[k].hi_b    = DATA_W'(src_b[k] >> SLICE);
        st_d[k].lo_diff = DATA_W'({d_s[k], src_lo[k][WIDTH-1:SLICE]});
`ifdef SUB_FLAGS_EN
        st_d[k].msbs    = src_msbs[k];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
    end
  end

  assign in_ready   = ld[0];
  assign out_valid  = st_q[LAST].valid;
  assign diff       = st_q[LAST].lo_diff[WIDTH-1:0];
  assign borrow_out = st_q[LAST].borrow;

`ifdef SUB_FLAGS_EN
  logic [2:0]       flg_q, flg_d;
  logic [WIDTH-1:0] nxt_diff;

  assign nxt_diff = st_d[LAST].lo_diff[WIDTH-1:0];

  always_comb begin
    flg_d = flg_q;
    if (ld[LAST]) begin
      flg_d = '0;
      if (st_d[LAST].valid) begin
        flg_d[2] = (nxt_diff == '0);
        flg_d[1] = nxt_diff[WIDTH-1];
        flg_d[0] = (st_d[LAST].msbs[1] != st_d[LAST].msbs[0]) &&
                   (nxt_diff[WIDTH-1] != st_d[LAST].msbs[1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flg_q <= '0;
    else        flg_q <= flg_d;
  end

  assign {zero, neg, ovf} = flg_q;
`endif

  // Operand leftovers of the last stage and already-shifted-out diff bits.
  logic unused_bits;
  always_comb begin
    unused_bits = ^{st_q[LAST].hi_a, st_q[LAST].hi_b};
    for (int k = 0; k < STAGES; k++)
      unused_bits = unused_bits ^ (^src_lo[k][SLICE-1:0]);
`ifdef SUB_FLAGS_EN
    unused_bits = unused_bits ^ (^st_q[LAST].msbs);
`endif
  end
endmodule

// File: tb/tb_pipelined_sub64.sv
// Self-checking bench for pipelined_sub64 against a whole-word arithmetic model.
module tb_pipelined_sub64;
  localparam int W      = 64;
  localparam int STAGES = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SUB_FLAGS_EN
  logic         zero, neg, ovf;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         n;
    logic         o;
  } res_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_sub64 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_FLAGS_EN
    ,
    .zero       (zero),
    .neg        (neg),
    .ovf        (ovf)
`endif
  );

  function automatic res_t strip(input res_t r);
    res_t s;
    s = r;
`ifndef SUB_FLAGS_EN
    s.z = 1'b0;
    s.n = 1'b0;
    s.o = 1'b0;
`endif
    return s;
  endfunction

  // Reference: whole-word unsigned arithmetic, borrow from a 65-bit compare.
  function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
    res_t       r;
    logic [W:0] need;
    r      = '0;
    r.d    = aa - bb - W'(bi);
    need   = {1'b0, bb} + (W+1)'(bi);
    r.bo   = ({1'b0, aa} < need);
    r.z    = (r.d == '0);
    r.n    = r.d[W-1];
    r.o    = (aa[W-1] != bb[W-1]) && (r.d[W-1] != aa[W-1]);
    return strip(r);
  endfunction

  function automatic res_t cur();
    res_t r;
    r    = '0;
    r.d  = diff;
    r.bo = borrow_out;
`ifdef SUB_FLAGS_EN
    r.z  = zero;
    r.n  = neg;
    r.o  = ovf;
`endif
    return r;
  endfunction

  // Sends one op into an idle pipe; lat = edges after the accept edge until out_valid.
  task automatic run_one(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                         output res_t got, output int lat);
    got = '0;
    lat = -1;
    @(posedge clk); #1;
    a = aa; b = bb; borrow_in = bi; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = strip(cur());
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (diff !== '0) begin failures++; $display("FAIL reset_diff got=%h exp=0", diff); end
    checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL reset_borrow_out got=%b exp=0", borrow_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef SUB_FLAGS_EN
    checks++; if ({zero, neg, ovf} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {zero, neg, ovf}); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    // One op in flight, then reset two cycles after it was accepted.
    @(posedge clk); #1;
    a = 64'd100; b = 64'd3; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL reset_midop_no_output got=%0d exp=0", seen); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_midop_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_underflow();
    res_t got, exp;
    int   lat;
    run_one(64'd0, 64'd1, 1'b0, got, lat);
    exp = model(64'd0, 64'd1, 1'b0);
    checks++; if (got.d !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL underflow_diff got=%h exp=%h", got.d, 64'hFFFF_FFFF_FFFF_FFFF); end
    checks++; if (got.bo !== 1'b1) begin failures++; $display("FAIL underflow_borrow got=%b exp=1", got.bo); end
    checks++; if (got !== exp) begin failures++; $display("FAIL underflow_model got=%h exp=%h", got, exp); end
    // Registered at the accept edge, visible STAGES-1 edges later (4th edge counting the accept).
    checks++; if (lat != STAGES - 1) begin failures++; $display("FAIL latency got=%0d exp=%0d", lat, STAGES - 1); end
  endtask

  task automatic test_cross_borrow();
    res_t got;
    int   lat;
    run_one(64'h0001_0000_0000_0000, 64'd1, 1'b0, got, lat);
    checks++; if (got.d !== 64'h0000_FFFF_FFFF_FFFF) begin failures++; $display("FAIL cross_diff got=%h exp=%h", got.d, 64'h0000_FFFF_FFFF_FFFF); end
    checks++; if (got.bo !== 1'b0) begin failures++; $display("FAIL cross_borrow got=%b exp=0", got.bo); end
    run_one(64'd5, 64'd5, 1'b1, got, lat);
    checks++; if (got.d !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL borrow_in_diff got=%h exp=all ones", got.d); end
    checks++; if (got.bo !== 1'b1) begin failures++; $display("FAIL borrow_in_borrow got=%b exp=1", got.bo); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] av [8];
    logic [W-1:0] bv [8];
    logic         iv [8];
    res_t         cap, exp;
    int           idx, acc, got, bad;
    for (int i = 0; i < 8; i++) begin
      av[i] = {$urandom(), $urandom()};
      bv[i] = {$urandom(), $urandom()};
      iv[i] = 1'($urandom_range(0, 1));
    end
    exp_q.delete();
    idx = 0; acc = 0; got = 0; bad = 0; cap = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (idx < 8);
      if (idx < 8) begin a = av[idx]; b = bv[idx]; borrow_in = iv[idx]; end
      @(negedge clk);
      if (cyc == 4) begin
        cap = cur();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_full_out_valid got=%b exp=1", out_valid); end
      end
      if (cyc == 5) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++; if (acc != 4) begin failures++; $display("FAIL bp_accepts got=%0d exp=4", acc); end
        checks++; if (out_valid !== 1'b1 || cur() !== cap) begin failures++; $display("FAIL bp_stable got=%h exp=%h", cur(), cap); end
      end
      if (out_valid && out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (strip(cur()) !== exp) bad++;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, borrow_in));
        idx++; acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 8) begin failures++; $display("FAIL bp_drain_count got=%0d exp=8", got); end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_results got=%0d wrong exp=0", bad); end
  endtask

  task automatic test_full_rate();
    localparam int N = 1000;
    res_t exp;
    int   idx, got, bad, gaps, stalls, started;
    exp_q.delete();
    idx = 0; got = 0; bad = 0; gaps = 0; stalls = 0; started = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < N + 50 && got < N; cyc++) begin
      in_valid = (idx < N);
      if (idx < N) begin
        a = {$urandom(), $urandom()};
        b = ($urandom_range(0, 15) == 0) ? a : {$urandom(), $urandom()};
        borrow_in = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (strip(cur()) !== exp) begin
          failures++; bad++;
          if (bad <= 5) $display("FAIL full_rate_result got=%h exp=%h", strip(cur()), exp);
        end
        got++; started = 1;
      end else if (started != 0) begin
        gaps++;
      end
      if (in_valid) begin
        if (in_ready) begin exp_q.push_back(model(a, b, borrow_in)); idx++; end
        else stalls++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (got != N) begin failures++; $display("FAIL full_rate_count got=%0d exp=%0d", got, N); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL full_rate_gaps got=%0d exp=0", gaps); end
    checks++; if (stalls != 0) begin failures++; $display("FAIL full_rate_stalls got=%0d exp=0", stalls); end
  endtask

`ifdef SUB_FLAGS_EN
  task automatic test_flags();
    res_t got;
    int   lat;
    run_one(64'h8000_0000_0000_0000, 64'd1, 1'b0, got, lat);
    checks++; if (got.d !== 64'h7FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL flags_ovf_diff got=%h exp=%h", got.d, 64'h7FFF_FFFF_FFFF_FFFF); end
    checks++; if ({got.z, got.n, got.o} !== 3'b001) begin failures++; $display("FAIL flags_ovf got=%b exp=001", {got.z, got.n, got.o}); end
    run_one(64'd7, 64'd7, 1'b0, got, lat);
    checks++; if ({got.z, got.n, got.o} !== 3'b100) begin failures++; $display("FAIL flags_zero got=%b exp=100", {got.z, got.n, got.o}); end
  endtask
`endif

  initial begin
    test_reset();
    test_underflow();
    test_cross_borrow();
    test_backpressure();
    test_full_rate();
`ifdef SUB_FLAGS_EN
    test_flags();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
